// File: rtl/mmm_pkg.sv
// Shared definitions for the MMM stream transmitter: width helpers, TUSER
// field layout and transmitter FSM state encodings.
package mmm_pkg;

  // Bits needed to carry an inner dimension in the range 0..maxk
  function automatic int unsigned k_bits(input int unsigned maxk);
    return $clog2(maxk + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // TUSER layout on the first word of a transfer: {K, new_b}
  localparam int unsigned TUSER_NEWB_BIT = 0;
  localparam int unsigned TUSER_K_LSB    = 1;

  // Transmitter FSM states
  localparam int unsigned ST_W      = 2;
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_SEND_A = 2'd1;
  localparam logic [1:0]  ST_SEND_B = 2'd2;
  localparam logic [1:0]  ST_DRAIN  = 2'd3;

endpackage

// File: rtl/tx_skid_buf.sv
// Two-entry valid/ready skid register. The output entry drives the stream
// directly from flops; the second entry absorbs one word arriving while the
// output is stalled. The producer guarantees it never pushes into a full
// buffer, so there is no input-side ready.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_push, i_push_data word arriving from the read pipeline
//   i_ready             sink ready
//   o_valid, o_data     registered stream output
//   o_count             entries currently held (0..2)
module tx_skid_buf #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic         r_out_vld;
  logic         r_skid_vld;
  logic [W-1:0] r_out;
  logic [W-1:0] r_skid;
  logic         w_pop;

  assign w_pop   = r_out_vld & i_ready;
  assign o_valid = r_out_vld;
  assign o_data  = r_out;
  assign o_count = 2'(r_out_vld) + 2'(r_skid_vld);

  // Output entry only moves when empty or handshaking, keeping it stable under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_out      <= '0;
      r_skid     <= '0;
    end else if (!r_out_vld || w_pop) begin
      if (r_skid_vld) begin
        r_out      <= r_skid;
        r_out_vld  <= 1'b1;
        r_skid_vld <= i_push;
        if (i_push) r_skid <= i_push_data;
      end else begin
        r_out_vld <= i_push;
        if (i_push) r_out <= i_push_data;
      end
    end else if (i_push) begin
      r_skid     <= i_push_data;
      r_skid_vld <= 1'b1;
    end
  end

endmodule

// File: rtl/mmm_stream_tx.sv
// AXI-Stream transmitter for the MMM input port. Holds one A (MxK) and one
// B (KxN) operand set in local RAMs loaded by a host write port; on start it
// streams A row-major, then optionally B row-major, tagging the first word
// with TUSER = {K, new_b}.
// Ports:
//   clk, reset                     clock, async active-low reset
//   wr_en/wr_sel_b/wr_addr/wr_data host buffer write (ignored while busy)
//   start/start_k/start_new_b      transfer request, sampled only in IDLE
//   busy, done, err_k              status (done/err_k are 1-cycle pulses)
//   AXIS_TDATA/TVALID/TUSER/TREADY stream to MMM
module mmm_stream_tx
  import mmm_pkg::*;
#(
  parameter int unsigned INW    = 12,
  parameter int unsigned M      = 7,
  parameter int unsigned N      = 9,
  parameter int unsigned MAXK   = 8,
  parameter int unsigned K_BITS = k_bits(MAXK),
  parameter int unsigned AW     = $clog2(MAXK * max_u(M, N))
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_sel_b,
  input  logic [AW-1:0]     wr_addr,
  input  logic [INW-1:0]    wr_data,
  input  logic              start,
  input  logic [K_BITS-1:0] start_k,
  input  logic              start_new_b,
  output logic              busy,
  output logic              done,
  output logic              err_k,
  output logic [INW-1:0]    AXIS_TDATA,
  output logic              AXIS_TVALID,
  output logic [K_BITS:0]   AXIS_TUSER,
  input  logic              AXIS_TREADY
);

  localparam int unsigned CW      = AW + 1;
  localparam int unsigned A_DEPTH = M * MAXK;
  localparam int unsigned B_DEPTH = MAXK * N;
  localparam int unsigned A_AW    = $clog2(A_DEPTH);
  localparam int unsigned B_AW    = $clog2(B_DEPTH);
  localparam int unsigned UW      = K_BITS + 1;
  localparam int unsigned SW      = UW + INW;

  logic [ST_W-1:0]   r_state, w_state_nxt;
  logic [AW-1:0]     r_rd_addr, w_addr_nxt;
  logic [K_BITS-1:0] r_k, w_k_nxt;
  logic              r_new_b, w_new_b_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic              r_rd_vld, r_rd_sel_b, r_rd_first;
  logic              w_rd_issue, w_rd_sel_b, w_rd_first;

  logic [INW-1:0]    r_a_mem [A_DEPTH];
  logic [INW-1:0]    r_b_mem [B_DEPTH];
  logic [INW-1:0]    r_a_dout, r_b_dout;
  logic [INW-1:0]    w_rd_data;
  logic [UW-1:0]     w_tuser_push;
  logic [SW-1:0]     w_sk_data;
  logic [1:0]        w_sk_cnt;
  logic              w_pop;
  logic [2:0]        w_occ;
  logic              w_room;
  logic              w_wr_a_ok, w_wr_b_ok;
  logic              w_k_ok;
  logic [K_BITS-1:0] w_k_eff;
  logic [CW-1:0]     w_a_last, w_b_last;
  logic              w_a_last_hit, w_b_last_hit;

  assign busy  = r_busy;
  assign done  = r_done;
  assign err_k = r_err;

  // Host writes, dropped while busy or out of range
  assign w_wr_a_ok = wr_en & ~r_busy & ~wr_sel_b & ({1'b0, wr_addr} < CW'(A_DEPTH));
  assign w_wr_b_ok = wr_en & ~r_busy &  wr_sel_b & ({1'b0, wr_addr} < CW'(B_DEPTH));

  // Operand RAMs: one write port for the host, one registered read port for the stream
  always_ff @(posedge clk) begin
    if (w_wr_a_ok) r_a_mem[A_AW'(wr_addr)] <= wr_data;
    if (w_wr_b_ok) r_b_mem[B_AW'(wr_addr)] <= wr_data;
    if (w_rd_issue && !w_rd_sel_b) r_a_dout <= r_a_mem[A_AW'(r_rd_addr)];
    if (w_rd_issue &&  w_rd_sel_b) r_b_dout <= r_b_mem[B_AW'(r_rd_addr)];
  end

  assign w_rd_data = r_rd_sel_b ? r_b_dout : r_a_dout;

  // Only the first word of a transfer carries {K, new_b}
  always_comb begin
    w_tuser_push = '0;
    if (r_rd_first) begin
      w_tuser_push[TUSER_NEWB_BIT]         = r_new_b;
      w_tuser_push[TUSER_K_LSB +: K_BITS]  = r_k;
    end
  end

  tx_skid_buf #(.W(SW)) u_skid (
    .clk         (clk),
    .rst_n       (reset),
    .i_push      (r_rd_vld),
    .i_push_data ({w_tuser_push, w_rd_data}),
    .i_ready     (AXIS_TREADY),
    .o_valid     (AXIS_TVALID),
    .o_data      (w_sk_data),
    .o_count     (w_sk_cnt)
  );

  assign AXIS_TDATA = w_sk_data[INW-1:0];
  assign AXIS_TUSER = w_sk_data[SW-1:INW];

  // Words held or in flight once this cycle's handshake completes; a new read keeps it <= 2
  assign w_pop  = AXIS_TVALID & AXIS_TREADY;
  assign w_occ  = 3'(w_sk_cnt) + 3'(r_rd_vld) - 3'(w_pop);
  assign w_room = (w_occ < 3'd2);

  // In IDLE the incoming start_k sizes the first read; afterwards the latched K does
  assign w_k_ok       = (start_k != '0) && (start_k <= K_BITS'(MAXK));
  assign w_k_eff      = (r_state == ST_IDLE) ? start_k : r_k;
  assign w_a_last     = CW'(M) * CW'(w_k_eff) - CW'(1);
  assign w_b_last     = CW'(w_k_eff) * CW'(N) - CW'(1);
  assign w_a_last_hit = ({1'b0, r_rd_addr} == w_a_last);
  assign w_b_last_hit = ({1'b0, r_rd_addr} == w_b_last);

  // Next-state and read-issue logic; the first A read is issued on the accept cycle
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_rd_addr;
    w_k_nxt     = r_k;
    w_new_b_nxt = r_new_b;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_rd_issue  = 1'b0;
    w_rd_sel_b  = 1'b0;
    w_rd_first  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_k_ok) begin
            w_k_nxt     = start_k;
            w_new_b_nxt = start_new_b;
            w_busy_nxt  = 1'b1;
            w_rd_issue  = 1'b1;
            w_rd_first  = 1'b1;
            if (w_a_last_hit) begin
              w_addr_nxt  = '0;
              w_state_nxt = start_new_b ? ST_SEND_B : ST_DRAIN;
            end else begin
              w_addr_nxt  = r_rd_addr + AW'(1);
              w_state_nxt = ST_SEND_A;
            end
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_SEND_A: begin
        if (w_room) begin
          w_rd_issue = 1'b1;
          if (w_a_last_hit) begin
            w_addr_nxt  = '0;
            w_state_nxt = r_new_b ? ST_SEND_B : ST_DRAIN;
          end else begin
            w_addr_nxt = r_rd_addr + AW'(1);
          end
        end
      end
      ST_SEND_B: begin
        if (w_room) begin
          w_rd_issue = 1'b1;
          w_rd_sel_b = 1'b1;
          if (w_b_last_hit) begin
            w_addr_nxt  = '0;
            w_state_nxt = ST_DRAIN;
          end else begin
            w_addr_nxt = r_rd_addr + AW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Finish as the last word handshakes so done/!busy land on the next cycle
        if (w_occ == 3'd0) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_rd_addr  <= '0;
      r_k        <= '0;
      r_new_b    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_rd_sel_b <= 1'b0;
      r_rd_first <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_addr  <= w_addr_nxt;
      r_k        <= w_k_nxt;
      r_new_b    <= w_new_b_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_rd_vld   <= w_rd_issue;
      r_rd_sel_b <= w_rd_sel_b;
      r_rd_first <= w_rd_first;
    end
  end

endmodule
